// File: rtl/inst_prefetch_bridge.sv
// Instruction prefetch bridge between the openmips fetch port and a pipelined
// instruction memory with fixed read latency. Sequential words are fetched
// ahead into a small FIFO so in-order fetches are served one per cycle; a
// fetch to any other address flushes the FIFO and restarts the stream there.
module inst_prefetch_bridge #(
    parameter int            AW       = 32,
    parameter int            DW       = 32,
    parameter int            DEPTH    = 4,
    parameter int            MEM_LAT  = 2,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cpu_req_i,
    input  logic [AW-1:0] cpu_addr_i,
    output logic [DW-1:0] cpu_inst_o,
    output logic          cpu_valid_o,
    output logic          cpu_stall_o,
    output logic          mem_ce_o,
    output logic [AW-1:0] mem_addr_o,
    input  logic [DW-1:0] mem_data_i
);

    // Stage 0 mirrors the registered mem_ce_o; stage MEM_LAT is the read
    // whose data is on mem_data_i this cycle.
    localparam int            NSTG      = MEM_LAT + 1;
    localparam int            PW        = $clog2(DEPTH);
    localparam int            CW        = $clog2(DEPTH + MEM_LAT + 2) + 1;
    localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
    localparam logic [AW-1:0] WORD_STEP = AW'(32'd4);

    logic [DW-1:0]   fifo_mem [DEPTH];
    logic [PW-1:0]   rd_ptr_r;
    logic [PW-1:0]   wr_ptr_r;
    logic [CW-1:0]   count_r;
    logic [AW-1:0]   exp_addr_r;
    logic [AW-1:0]   fetch_addr_r;
    logic            epoch_r;
    logic [NSTG-1:0] stg_vld_r;
    logic [NSTG-1:0] stg_epoch_r;
    logic            mem_ce_r;
    logic [AW-1:0]   mem_addr_r;

    logic            addr_match_s;
    logic            fifo_empty_s;
    logic            hit_s;
    logic            redirect_s;
    logic            ret_ok_s;
    logic            fifo_wr_s;
    logic            issue_s;
    logic [CW-1:0]   inflight_s;
    logic [CW-1:0]   credit_s;

    // Request decode, return acceptance and credit-based issue decision.
    always_comb begin
        addr_match_s = (cpu_addr_i == exp_addr_r);
        fifo_empty_s = (count_r == '0);
        hit_s        = cpu_req_i && addr_match_s && !fifo_empty_s;
        redirect_s   = cpu_req_i && !addr_match_s;
        ret_ok_s     = stg_vld_r[MEM_LAT] && (stg_epoch_r[MEM_LAT] == epoch_r);
        fifo_wr_s    = rst_n && !redirect_s && ret_ok_s;
        inflight_s   = '0;
        for (int i = 0; i < NSTG; i++) begin
            inflight_s = inflight_s + CW'(stg_vld_r[i] && (stg_epoch_r[i] == epoch_r));
        end
        // A pop this cycle frees its slot for this cycle's decision.
        credit_s     = inflight_s + count_r - CW'(hit_s);
        issue_s      = !redirect_s && (credit_s < DEPTH_C);
    end

    // Outputs are forced quiet while reset is asserted.
    always_comb begin
        cpu_inst_o  = fifo_mem[rd_ptr_r];
        cpu_valid_o = rst_n && hit_s;
        cpu_stall_o = rst_n && cpu_req_i && !hit_s;
        mem_ce_o    = rst_n && mem_ce_r;
        if (rst_n) begin
            mem_addr_o = mem_addr_r;
        end else begin
            mem_addr_o = '0;
        end
    end

    // Control state: addresses, epoch, in-flight tracker, memory strobe, FIFO pointers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr_r     <= '0;
            wr_ptr_r     <= '0;
            count_r      <= '0;
            exp_addr_r   <= RESET_PC;
            fetch_addr_r <= RESET_PC;
            epoch_r      <= 1'b0;
            stg_vld_r    <= '0;
            stg_epoch_r  <= '0;
            mem_ce_r     <= 1'b0;
            mem_addr_r   <= '0;
        end else if (redirect_s) begin
            // The first read of the new stream is launched straight from the
            // requested address; every older read is discarded.
            epoch_r      <= ~epoch_r;
            exp_addr_r   <= cpu_addr_i;
            fetch_addr_r <= cpu_addr_i + WORD_STEP;
            stg_vld_r    <= {{(NSTG-1){1'b0}}, 1'b1};
            stg_epoch_r  <= {NSTG{~epoch_r}};
            mem_ce_r     <= 1'b1;
            mem_addr_r   <= cpu_addr_i;
            rd_ptr_r     <= '0;
            wr_ptr_r     <= '0;
            count_r      <= '0;
        end else begin
            stg_vld_r   <= {stg_vld_r[NSTG-2:0], issue_s};
            stg_epoch_r <= {stg_epoch_r[NSTG-2:0], epoch_r};
            mem_ce_r    <= issue_s;
            if (issue_s) begin
                mem_addr_r   <= fetch_addr_r;
                fetch_addr_r <= fetch_addr_r + WORD_STEP;
            end
            if (hit_s) begin
                exp_addr_r <= exp_addr_r + WORD_STEP;
                rd_ptr_r   <= rd_ptr_r + PW'(1'b1);
            end
            if (fifo_wr_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1'b1);
            end
            count_r <= count_r + CW'(fifo_wr_s) - CW'(hit_s);
        end
    end

    // FIFO storage: accepted memory returns are written at the tail.
    always_ff @(posedge clk) begin
        if (fifo_wr_s) begin
            fifo_mem[wr_ptr_r] <= mem_data_i;
        end
    end

endmodule

// File: tb/tb_inst_prefetch_bridge.sv
// Self-checking bench for inst_prefetch_bridge: a latency-2 memory model
// returning ~addr, a CPU fetch task, and a scoreboard of expected instructions.
module tb_inst_prefetch_bridge;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_req_i;
    logic [31:0] cpu_addr_i;
    logic [31:0] cpu_inst_o;
    logic        cpu_valid_o;
    logic        cpu_stall_o;
    logic        mem_ce_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_data_i;

    int checks   = 0;
    int failures = 0;
    logic [31:0] sb [$];

    inst_prefetch_bridge #(
        .AW(32), .DW(32), .DEPTH(4), .MEM_LAT(2), .RESET_PC(32'h0000_0000)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cpu_req_i  (cpu_req_i),
        .cpu_addr_i (cpu_addr_i),
        .cpu_inst_o (cpu_inst_o),
        .cpu_valid_o(cpu_valid_o),
        .cpu_stall_o(cpu_stall_o),
        .mem_ce_o   (mem_ce_o),
        .mem_addr_o (mem_addr_o),
        .mem_data_i (mem_data_i)
    );

    always #5 clk = ~clk;

    // Memory model: data = ~addr, exactly two cycles after the strobe.
    logic        p1_v = 1'b0;
    logic        p2_v = 1'b0;
    logic [31:0] p1_a = 32'h0;
    logic [31:0] p2_a = 32'h0;
    always @(posedge clk) begin
        p1_v <= mem_ce_o;
        p1_a <= mem_addr_o;
        p2_v <= p1_v;
        p2_a <= p1_a;
    end
    assign mem_data_i = p2_v ? ~p2_a : 32'h5A5A_5A5A;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Scoreboard: every served instruction must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && cpu_valid_o === 1'b1) begin
            check_eq("sb_nonempty", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                check_eq("cpu_inst", cpu_inst_o, sb.pop_front());
            end
        end
    end

    // Drive one fetch from just after a rising edge; hold it until served.
    task automatic fetch(input logic [31:0] a, output int stalls);
        bit served;
        served = 1'b0;
        stalls = 0;
        cpu_req_i  = 1'b1;
        cpu_addr_i = a;
        sb.push_back(~a);
        for (int k = 0; k < 40 && !served; k++) begin
            @(negedge clk);
            if (cpu_valid_o) served = 1'b1;
            else             stalls++;
        end
        check_eq("fetch_served", 32'(served), 32'd1);
        @(posedge clk); #1;
        cpu_req_i = 1'b0;
    endtask

    // One-cycle request that is expected to stall (used for redirects not served).
    task automatic poke(input logic [31:0] a);
        cpu_req_i  = 1'b1;
        cpu_addr_i = a;
        @(negedge clk);
        check_eq("poke_stall", 32'(cpu_stall_o), 32'd1);
        check_eq("poke_valid", 32'(cpu_valid_o), 32'd0);
        @(posedge clk); #1;
        cpu_req_i = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int st;
        logic [31:0] base;
        rst_n      = 1'b0;
        cpu_req_i  = 1'b1;
        cpu_addr_i = 32'h40;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check_eq("rst_ce",    32'(mem_ce_o),    32'd0);
        check_eq("rst_addr",  mem_addr_o,       32'd0);
        check_eq("rst_valid", 32'(cpu_valid_o), 32'd0);
        check_eq("rst_stall", 32'(cpu_stall_o), 32'd0);
        @(posedge clk); #1;
        rst_n      = 1'b1;
        cpu_req_i  = 1'b0;
        cpu_addr_i = 32'h0;

        // Initial prefetch: strobes on cycles 1..4 at 0,4,8,C, then idle.
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            check_eq("init_ce", 32'(mem_ce_o), 32'((c >= 1) && (c <= 4)));
            if ((c >= 1) && (c <= 4)) check_eq("init_addr", mem_addr_o, 32'((c - 1) * 4));
        end
        @(posedge clk); #1;

        // Sequential stream at full rate.
        for (int i = 0; i < 16; i++) begin
            fetch(32'(i * 4), st);
            check_eq("seq_stall", 32'(st), 32'd0);
        end

        // Single redirect: MEM_LAT+2 stall cycles, then full rate.
        fetch(32'h100, st);
        check_eq("redir_stall", 32'(st), 32'd4);
        for (int i = 1; i < 4; i++) begin
            fetch(32'h100 + 32'(i * 4), st);
            check_eq("redir_seq_stall", 32'(st), 32'd0);
        end

        // Back-to-back redirects: only the last stream is delivered.
        poke(32'h200);
        fetch(32'h300, st);
        check_eq("b2b_stall", 32'(st), 32'd4);
        for (int i = 1; i < 3; i++) begin
            fetch(32'h300 + 32'(i * 4), st);
            check_eq("b2b_seq_stall", 32'(st), 32'd0);
        end

        // Address wrap across 2^32.
        base = 32'hFFFF_FFF8;
        fetch(base, st);
        check_eq("wrap_first_stall", 32'(st), 32'd4);
        for (int i = 1; i < 4; i++) begin
            fetch(base + 32'(i * 4), st);
            check_eq("wrap_stall", 32'(st), 32'd0);
        end

        // Reset with reads in flight: their returns must be dropped.
        poke(32'h500);
        @(posedge clk); #1;
        rst_n      = 1'b0;
        cpu_req_i  = 1'b1;
        cpu_addr_i = 32'h500;
        @(negedge clk);
        check_eq("mid_rst_ce",    32'(mem_ce_o),    32'd0);
        check_eq("mid_rst_valid", 32'(cpu_valid_o), 32'd0);
        check_eq("mid_rst_stall", 32'(cpu_stall_o), 32'd0);
        @(posedge clk); #1;
        rst_n      = 1'b1;
        cpu_req_i  = 1'b0;
        cpu_addr_i = 32'h0;
        @(negedge clk);
        check_eq("post_rst_ce0", 32'(mem_ce_o), 32'd0);
        @(negedge clk);
        check_eq("post_rst_ce1", 32'(mem_ce_o), 32'd1);
        check_eq("post_rst_addr", mem_addr_o, 32'h0);
        @(posedge clk); #1;
        fetch(32'h0, st);
        fetch(32'h4, st);
        check_eq("post_rst_seq4", 32'(st), 32'd0);
        fetch(32'h8, st);
        check_eq("post_rst_seq8", 32'(st), 32'd0);

        repeat (3) @(posedge clk);
        #1;
        check_eq("sb_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
